// File: rtl/alu_pkg.sv
// Shared definitions for the parity arithmetic unit: opcode bit positions,
// FSM state encoding and a one-hot opcode check.
package alu_pkg;

    localparam int OP_W   = 6;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_MUL = 2;
    localparam int OP_AND = 3;
    localparam int OP_OR  = 4;
    localparam int OP_XOR = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic is_onehot(input logic [OP_W-1:0] op);
        int n;
        n = 0;
        for (int i = 0; i < OP_W; i++) begin
            n += int'(op[i]);
        end
        return (n == 1);
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational even-parity detector: even_o is 1 when data_i holds an even
// number of ones.
module parity_reduce #(
    parameter int W = 10
) (
    input  logic [W-1:0] data_i,
    output logic         even_o
);

    assign even_o = ~^data_i;

endmodule

// File: rtl/parity_arith_unit.sv
// Handshaked arithmetic/logic unit with a shift-add multiplier and an
// even-parity flag computed on the raw (unextended) result.
module parity_arith_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 5,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     Number1,
    input  logic [WIDTH-1:0]     Number2,
    input  logic [OP_W-1:0]      printout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] conclusion,
    output logic                 balancebit,
    output logic                 op_error
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 2) begin : g_bad_width
        $error("parity_arith_unit: WIDTH must be at least 2");
    end
    if (OUT_WIDTH < PW) begin : g_bad_out_width
        $error("parity_arith_unit: OUT_WIDTH must be at least 2*WIDTH");
    end

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [PW-1:0]          acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]       mpl_q, mpl_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   conc_q, conc_d;
    logic                   bal_q, bal_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;

    logic                   accept;
    logic [WIDTH:0]         arith_res;
    logic [WIDTH-1:0]       logic_res;
    logic [OUT_WIDTH-1:0]   exec_conc, mul_conc;
    logic [PW-1:0]          exec_pad, step_acc, parity_in;
    logic                   exec_err, parity_even;

    assign in_ready   = (state_q == IDLE) && !reset;
    assign accept     = in_valid && in_ready;
    assign out_valid  = valid_q;
    assign conclusion = conc_q;
    assign balancebit = bal_q;
    assign op_error   = err_q;

    // Single-cycle result for add/sub/logic and invalid opcodes. The add
    // carry lands in the top raw bit and is then treated as the sign.
    always_comb begin
        arith_res = '0;
        logic_res = '0;
        exec_conc = '0;
        exec_pad  = '0;
        exec_err  = 1'b0;
        if (!is_onehot(op_q)) begin
            exec_err = 1'b1;
        end else if (op_q[OP_ADD] || op_q[OP_SUB]) begin
            arith_res = op_q[OP_ADD] ? ({1'b0, a_q} + {1'b0, b_q})
                                     : ({1'b0, a_q} - {1'b0, b_q});
            exec_conc            = {OUT_WIDTH{arith_res[WIDTH]}};
            exec_conc[WIDTH:0]   = arith_res;
            exec_pad[WIDTH:0]    = arith_res;
        end else if (op_q[OP_AND] || op_q[OP_OR] || op_q[OP_XOR]) begin
            if (op_q[OP_AND])     logic_res = a_q & b_q;
            else if (op_q[OP_OR]) logic_res = a_q | b_q;
            else                  logic_res = a_q ^ b_q;
            exec_conc[WIDTH-1:0] = logic_res;
            exec_pad[WIDTH-1:0]  = logic_res;
        end
    end

    // One shift-add step; on the final step this is already the full product.
    assign step_acc  = mpl_q[0] ? (acc_q + mcand_q) : acc_q;
    assign parity_in = (state_q == MUL) ? step_acc : exec_pad;

    always_comb begin
        mul_conc         = '0;
        mul_conc[PW-1:0] = step_acc;
    end

    parity_reduce #(.W(PW)) u_parity (
        .data_i (parity_in),
        .even_o (parity_even)
    );

    // Next-state logic: capture on accept, run EXEC or MUL, publish on DONE entry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        mpl_d   = mpl_q;
        cnt_d   = cnt_q;
        conc_d  = conc_q;
        bal_d   = bal_q;
        err_d   = err_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d  = Number1;
                    b_d  = Number2;
                    op_d = printout;
                    if (is_onehot(printout) && printout[OP_MUL]) begin
                        acc_d   = '0;
                        mcand_d = PW'(Number1);
                        mpl_d   = Number2;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                conc_d  = exec_conc;
                bal_d   = parity_even;
                err_d   = exec_err;
                valid_d = 1'b1;
                state_d = DONE;
            end
            MUL: begin
                acc_d   = step_acc;
                mcand_d = mcand_q << 1;
                mpl_d   = mpl_q >> 1;
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    conc_d  = mul_conc;
                    bal_d   = parity_even;
                    err_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mpl_q   <= '0;
            cnt_q   <= '0;
            conc_q  <= '0;
            bal_q   <= 1'b1;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mpl_q   <= mpl_d;
            cnt_q   <= cnt_d;
            conc_q  <= conc_d;
            bal_q   <= bal_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

endmodule
